// File: rtl/sound_pkg.sv
// Shared types and timing constants for the sound playback arbiter.
// PLAY_CYCLES is derived from the codec sample rate and the system clock.
package sound_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PLAY = 2'b01,
    GAP  = 2'b10
  } state_t;

  localparam int CLK_FREQUENCY  = 50_000_000;
  localparam int MCLK_FREQUENCY = 2_048_000;
  localparam int FUNDAMENTAL_SR = MCLK_FREQUENCY / 256;
  localparam int NUM_OF_SAMPLES = 1023;

  // One extra sample slot covers the restart at sample 0 after the rising edge.
  localparam int PLAY_CYCLES = (CLK_FREQUENCY / FUNDAMENTAL_SR) * (NUM_OF_SAMPLES + 1);

  localparam logic SAMPLE_SINE  = 1'b0;
  localparam logic SAMPLE_QUACK = 1'b1;

endpackage

// File: rtl/prio_encoder.sv
// Fixed-priority encoder (lowest index wins) with a flag telling whether any
// set bit sits strictly below a given threshold index.
module prio_encoder #(
  parameter int NUM_REQ = 4,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] pending,
  input  logic [ID_W-1:0]    thresh,
  output logic               valid,
  output logic [ID_W-1:0]    idx,
  output logic               lower_exists
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    valid        = 1'b0;
    idx          = '0;
    lower_exists = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      valid        = valid | pending[i];
      idx          = pending[i] ? ID_W'(i) : idx;
      lower_exists = lower_exists | (pending[i] & (ID_W'(i) < thresh));
    end
  end

endmodule

// File: rtl/sound_arbiter.sv
// Shares the codec playback path between NUM_REQ sound-event requesters,
// granting latched requests by fixed priority with a forced low gap between grants.
module sound_arbiter #(
  parameter int                 NUM_REQ     = 4,
  parameter int                 PLAY_CYCLES = sound_pkg::PLAY_CYCLES,
  parameter int                 GAP_CYCLES  = 4,
  parameter logic [NUM_REQ-1:0] SAMPLE_MAP  = NUM_REQ'(4'b1010),
  parameter int                 CNT_W       = 23,
  localparam int                ID_W        = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable_in,
  input  logic [NUM_REQ-1:0] req,
  output logic               sound_enable,
  output logic               sound_input,
  output logic               sound_sample_select,
  output logic               busy,
  output logic [ID_W-1:0]    active_id,
  output logic [NUM_REQ-1:0] done,
  output logic               preempted
);

  import sound_pkg::*;

  state_t             state_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [NUM_REQ-1:0] pending_r;

  logic               grant_valid_s;
  logic [ID_W-1:0]    grant_id_s;
  logic               lower_exists_s;
  logic [NUM_REQ-1:0] grant_mask_s;
  logic [NUM_REQ-1:0] done_mask_s;
  logic               play_last_s;
  logic               gap_last_s;

  assign grant_mask_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id_s;
  assign done_mask_s  = {{(NUM_REQ-1){1'b0}}, 1'b1} << active_id;
  assign play_last_s  = (cnt_r == CNT_W'(PLAY_CYCLES - 1));
  assign gap_last_s   = (cnt_r == CNT_W'(GAP_CYCLES - 1));

  prio_encoder #(
    .NUM_REQ(NUM_REQ)
  ) u_prio_encoder (
    .pending     (pending_r),
    .thresh      (active_id),
    .valid       (grant_valid_s),
    .idx         (grant_id_s),
    .lower_exists(lower_exists_s)
  );

  // Arbitration FSM with play/gap counter, pending latch and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r             <= IDLE;
      cnt_r               <= '0;
      pending_r           <= '0;
      sound_enable        <= 1'b0;
      sound_input         <= 1'b0;
      sound_sample_select <= SAMPLE_SINE;
      busy                <= 1'b0;
      active_id           <= '0;
      done                <= '0;
      preempted           <= 1'b0;
    end else begin
      sound_enable <= enable_in;
      done         <= '0;
      preempted    <= 1'b0;
      if (!enable_in) begin
        // Mute flushes everything queued; grant history (id/select) is kept.
        state_r     <= IDLE;
        cnt_r       <= '0;
        pending_r   <= '0;
        sound_input <= 1'b0;
        busy        <= 1'b0;
      end else begin
        pending_r <= pending_r | req;
        case (state_r)
          IDLE: begin
            if (grant_valid_s) begin
              // A simultaneous new pulse on the granted bit re-queues it.
              pending_r           <= (pending_r & ~grant_mask_s) | req;
              state_r             <= PLAY;
              cnt_r               <= '0;
              sound_input         <= 1'b1;
              sound_sample_select <= SAMPLE_MAP[grant_id_s];
              active_id           <= grant_id_s;
              busy                <= 1'b1;
            end
          end
          PLAY: begin
            if (play_last_s) begin
              state_r     <= GAP;
              cnt_r       <= '0;
              sound_input <= 1'b0;
              done        <= done_mask_s;
            end else if (lower_exists_s) begin
              state_r     <= GAP;
              cnt_r       <= '0;
              sound_input <= 1'b0;
              preempted   <= 1'b1;
            end else begin
              cnt_r <= cnt_r + CNT_W'(1'b1);
            end
          end
          GAP: begin
            if (gap_last_s) begin
              state_r <= IDLE;
              cnt_r   <= '0;
              busy    <= 1'b0;
            end else begin
              cnt_r <= cnt_r + CNT_W'(1'b1);
            end
          end
          default: begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            sound_input <= 1'b0;
            busy        <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sound_arbiter.sv
// Directed bench for sound_arbiter: a per-cycle vector table for the basic
// grant/mute flow, then scripted sequences for priority, preemption and reset.
module tb_sound_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable_in;
  logic [3:0] req;
  logic       sound_enable;
  logic       sound_input;
  logic       sound_sample_select;
  logic       busy;
  logic [1:0] active_id;
  logic [3:0] done;
  logic       preempted;

  sound_arbiter #(
    .NUM_REQ    (4),
    .PLAY_CYCLES(20),
    .GAP_CYCLES (4),
    .SAMPLE_MAP (4'b1010),
    .CNT_W      (5)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .enable_in          (enable_in),
    .req                (req),
    .sound_enable       (sound_enable),
    .sound_input        (sound_input),
    .sound_sample_select(sound_sample_select),
    .busy               (busy),
    .active_id          (active_id),
    .done               (done),
    .preempted          (preempted)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int rise_cnt = 0;
  int done2_cnt = 0;

  always @(posedge sound_input) rise_cnt++;

  always @(posedge clk) if (done[2] === 1'b1) done2_cnt++;

  wire [10:0] act = {sound_enable, sound_input, sound_sample_select, busy,
                     active_id, done, preempted};

  function automatic logic [10:0] pk(int se, int si, int sel, int bsy, int id, int dn, int pre);
    return {se[0], si[0], sel[0], bsy[0], id[1:0], dn[3:0], pre[0]};
  endfunction

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_o(string name, logic [10:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got {en,in,sel,busy,id,done,pre}=%b_%b_%b_%b_%b_%b_%b expected %b_%b_%b_%b_%b_%b_%b",
               name, act[10], act[9], act[8], act[7], act[6:5], act[4:1], act[0],
               exp[10], exp[9], exp[8], exp[7], exp[6:5], exp[4:1], exp[0]);
    end
  endtask

  task automatic chk_i(string name, int a, int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, a, e);
    end
  endtask

  typedef struct {
    logic       rst_n;
    logic       en;
    logic [3:0] req;
    int         reps;
    logic [10:0] exp;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int r0;
    int d0;

    // Reset, single grant of requester 1 (quack), gap, then mute with requests.
    vecs[0] = '{1'b0, 1'b1, 4'b0000, 1,  pk(0, 0, 0, 0, 0, 0, 0)};
    vecs[1] = '{1'b1, 1'b1, 4'b0000, 1,  pk(1, 0, 0, 0, 0, 0, 0)};
    vecs[2] = '{1'b1, 1'b1, 4'b0010, 1,  pk(1, 0, 0, 0, 0, 0, 0)};
    vecs[3] = '{1'b1, 1'b1, 4'b0000, 1,  pk(1, 1, 1, 1, 1, 0, 0)};
    vecs[4] = '{1'b1, 1'b1, 4'b0000, 19, pk(1, 1, 1, 1, 1, 0, 0)};
    vecs[5] = '{1'b1, 1'b1, 4'b0000, 1,  pk(1, 0, 1, 1, 1, 2, 0)};
    vecs[6] = '{1'b1, 1'b1, 4'b0000, 3,  pk(1, 0, 1, 1, 1, 0, 0)};
    vecs[7] = '{1'b1, 1'b1, 4'b0000, 1,  pk(1, 0, 1, 0, 1, 0, 0)};
    vecs[8] = '{1'b1, 1'b0, 4'b1111, 1,  pk(0, 0, 1, 0, 1, 0, 0)};
    vecs[9] = '{1'b1, 1'b1, 4'b0000, 3,  pk(1, 0, 1, 0, 1, 0, 0)};

    rst_n     = 1'b0;
    enable_in = 1'b0;
    req       = 4'b0000;
    tick(2);

    for (int v = 0; v < 10; v++) begin
      rst_n     = vecs[v].rst_n;
      enable_in = vecs[v].en;
      req       = vecs[v].req;
      for (int r = 0; r < vecs[v].reps; r++) begin
        tick();
        chk_o($sformatf("vec%0d_cyc%0d", v, r), vecs[v].exp);
      end
    end
    req = 4'b0000;

    // Simultaneous requests 0 and 3: 0 first, then 3 after the gap.
    r0 = rise_cnt;
    req = 4'b1001;
    tick();
    req = 4'b0000;
    tick();
    chk_o("simul_grant0", pk(1, 1, 0, 1, 0, 0, 0));
    tick(19);
    chk_o("simul_play0_last", pk(1, 1, 0, 1, 0, 0, 0));
    tick();
    chk_o("simul_done0", pk(1, 0, 0, 1, 0, 1, 0));
    tick(4);
    chk_o("simul_idle_arb", pk(1, 0, 0, 0, 0, 0, 0));
    tick();
    chk_o("simul_grant3", pk(1, 1, 1, 1, 3, 0, 0));
    tick(19);
    chk_o("simul_play3_last", pk(1, 1, 1, 1, 3, 0, 0));
    tick();
    chk_o("simul_done3", pk(1, 0, 1, 1, 3, 8, 0));
    tick(4);
    chk_o("simul_idle", pk(1, 0, 1, 0, 3, 0, 0));
    chk_i("simul_rises", rise_cnt - r0, 2);

    // Preemption of requester 2 by requester 0 five cycles into play.
    d0 = done2_cnt;
    req = 4'b0100;
    tick();
    req = 4'b0000;
    tick();
    chk_o("pre_grant2", pk(1, 1, 0, 1, 2, 0, 0));
    tick(4);
    req = 4'b0001;
    tick();
    req = 4'b0000;
    chk_o("pre_still_play", pk(1, 1, 0, 1, 2, 0, 0));
    tick();
    chk_o("pre_pulse", pk(1, 0, 0, 1, 2, 0, 1));
    tick(3);
    chk_o("pre_gap", pk(1, 0, 0, 1, 2, 0, 0));
    tick();
    chk_o("pre_idle", pk(1, 0, 0, 0, 2, 0, 0));
    tick();
    chk_o("pre_grant0", pk(1, 1, 0, 1, 0, 0, 0));
    tick(19);
    chk_o("pre_play0_last", pk(1, 1, 0, 1, 0, 0, 0));
    tick();
    chk_o("pre_done0", pk(1, 0, 0, 1, 0, 1, 0));
    tick(4);
    chk_o("pre_idle_end", pk(1, 0, 0, 0, 0, 0, 0));
    chk_i("pre_no_done2", done2_cnt - d0, 0);

    // Lower priority request does not cut requester 1 short.
    req = 4'b0010;
    tick();
    req = 4'b0000;
    tick();
    chk_o("lo_grant1", pk(1, 1, 1, 1, 1, 0, 0));
    tick(3);
    req = 4'b1000;
    tick();
    req = 4'b0000;
    tick(15);
    chk_o("lo_no_preempt", pk(1, 1, 1, 1, 1, 0, 0));
    tick();
    chk_o("lo_done1", pk(1, 0, 1, 1, 1, 2, 0));
    tick(5);
    chk_o("lo_grant3", pk(1, 1, 1, 1, 3, 0, 0));

    // Mute mid-play with requester 3 re-queued; muted requests are dropped.
    tick(6);
    req = 4'b1000;
    tick();
    req = 4'b0000;
    enable_in = 1'b0;
    tick();
    chk_o("mute_stop", pk(0, 0, 1, 0, 3, 0, 0));
    req = 4'b1111;
    tick();
    req = 4'b0000;
    enable_in = 1'b1;
    r0 = rise_cnt;
    tick();
    chk_o("mute_reenable", pk(1, 0, 1, 0, 3, 0, 0));
    tick(4);
    chk_o("mute_no_grant", pk(1, 0, 1, 0, 3, 0, 0));
    chk_i("mute_rises", rise_cnt - r0, 0);

    // Reset mid-play with requester 3 pending, then a fresh grant.
    req = 4'b0010;
    tick();
    req = 4'b0000;
    tick();
    chk_o("rst_pre_grant1", pk(1, 1, 1, 1, 1, 0, 0));
    tick(2);
    req = 4'b1000;
    tick();
    req = 4'b0000;
    rst_n = 1'b0;
    tick();
    chk_o("rst_all_zero", pk(0, 0, 0, 0, 0, 0, 0));
    rst_n = 1'b1;
    tick();
    chk_o("rst_release", pk(1, 0, 0, 0, 0, 0, 0));
    tick(2);
    chk_o("rst_pending_flushed", pk(1, 0, 0, 0, 0, 0, 0));
    req = 4'b0010;
    tick();
    req = 4'b0000;
    chk_o("rst_latency1", pk(1, 0, 0, 0, 0, 0, 0));
    tick();
    chk_o("rst_grant1", pk(1, 1, 1, 1, 1, 0, 0));
    tick(20);
    chk_o("rst_done1", pk(1, 0, 1, 1, 1, 2, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
